// File: rtl/seq_gen_ctrl.sv
// Random digit-sequence generator: draws SEQ_LEN digits from a free-running LFSR and writes them to a sequence RAM.
// Optional macro SEQ_NO_REPEAT_EN forbids equal digits at consecutive addresses.
module seq_gen_ctrl #(
  parameter int          SEQ_LEN   = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       GoGen,
  input  logic [1:0] Diff,
  output logic       RAMWrEn,
  output logic [4:0] RAMAddr,
  output logic [3:0] RAMData,
  output logic       FinGen,
  output logic       Busy
);

  localparam logic [4:0] LAST_ADDR = 5'(SEQ_LEN - 1);

  typedef enum logic [2:0] {IDLE, DRAW, WRITE, NEXT, DONE} state_t;

  state_t      state, nextState;
  logic [15:0] lfsr;
  logic [4:0]  addrCnt;
  logic [3:0]  digitReg;
  logic [1:0]  diffLat;
  logic [3:0]  candidate;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] mapDigit(input logic [1:0] d, input logic [3:0] r);
    case (d)
      2'b10:   return {1'b0, r[2:0]} + 4'd1;
      2'b11:   return (r < 4'd10) ? r : r - 4'd10;
      default: return {2'b00, r[1:0]} + 4'd1;
    endcase
  endfunction

  assign candidate = mapDigit(diffLat, lfsr[3:0]);

`ifdef SEQ_NO_REPEAT_EN
  // digitReg still holds the previously written digit while redrawing
  logic repeatHit;
  assign repeatHit = (addrCnt != 5'd0) && (candidate == digitReg);
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (GoGen) nextState = DRAW;
`ifdef SEQ_NO_REPEAT_EN
      DRAW:  nextState = repeatHit ? DRAW : WRITE;
`else
      DRAW:  nextState = WRITE;
`endif
      WRITE: nextState = NEXT;
      NEXT:  nextState = (addrCnt == LAST_ADDR) ? DONE : DRAW;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // LFSR free-runs in every state so the draw depends on when GoGen arrives
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lfsr     <= LFSR_SEED;
      addrCnt  <= 5'd0;
      digitReg <= 4'd0;
      diffLat  <= 2'b01;
    end else begin
      lfsr <= lfsrStep(lfsr);
      if (state == IDLE && GoGen) begin
        diffLat <= Diff;
        addrCnt <= 5'd0;
      end
      if (state == DRAW && nextState == WRITE)
        digitReg <= candidate;
      if (state == NEXT && addrCnt != LAST_ADDR)
        addrCnt <= addrCnt + 5'd1;
    end
  end

  always_comb begin
    RAMWrEn = (state == WRITE);
    FinGen  = (state == DONE);
    Busy    = (state != IDLE);
    RAMAddr = addrCnt;
    RAMData = digitReg;
  end

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Directed self-checking bench for seq_gen_ctrl; digit values are predicted by a reference LFSR.
module tb_seq_gen_ctrl;

  logic       Clk = 1'b0;
  logic       Rst, GoGen;
  logic [1:0] Diff;
  logic       RAMWrEn, FinGen, Busy;
  logic [4:0] RAMAddr;
  logic [3:0] RAMData;

  int checks = 0;
  int errors = 0;

  seq_gen_ctrl dut (
    .Clk(Clk), .Rst(Rst), .GoGen(GoGen), .Diff(Diff),
    .RAMWrEn(RAMWrEn), .RAMAddr(RAMAddr), .RAMData(RAMData),
    .FinGen(FinGen), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: mPrev is the value present before the most recent edge
  logic [15:0] mLfsr, mPrev;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mLfsr <= 16'hACE1;
      mPrev <= 16'hACE1;
    end else begin
      mPrev <= mLfsr;
      mLfsr <= (mLfsr >> 1) ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  function automatic logic [3:0] refDigit(input logic [1:0] d, input logic [15:0] l);
    int v;
    v = l & 15;
    if (d == 2'b10) return 4'(1 + (l & 7));
    if (d == 2'b11) return (v < 10) ? 4'(v) : 4'(v - 10);
    return 4'(1 + (l & 3));
  endfunction

  int         nW, finAt;
  logic       busyAfter;
  logic [4:0] wrAddr [64];
  logic [3:0] wrData [64];
  logic [3:0] wrExp  [64];

  // Starts one run and records every write; finAt counts edges after the accepting edge
  task automatic capture(input logic [1:0] d, input bit toggle);
    @(negedge Clk); Diff = d; GoGen = 1'b1;
    @(posedge Clk);
    @(negedge Clk); GoGen = 1'b0;
    nW = 0; finAt = -1; busyAfter = 1'bx;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge Clk);
      if (RAMWrEn && nW < 64) begin
        wrAddr[nW] = RAMAddr; wrData[nW] = RAMData; wrExp[nW] = refDigit(d, mPrev); nW++;
      end
      if (finAt >= 0 && n == finAt + 1) begin busyAfter = Busy; break; end
      if (FinGen && finAt < 0) begin finAt = n; GoGen = 1'b0; end
      else if (toggle && finAt < 0) begin Diff = ~Diff; GoGen = ~GoGen; end
    end
    GoGen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk); Rst = 1'b0; GoGen = 1'b0; Diff = 2'b00;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk); Rst = 1'b0; GoGen = 1'b0; Diff = 2'b00;
    #1;
    checks++; if (RAMWrEn !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", RAMWrEn); end
    checks++; if (RAMAddr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", RAMAddr); end
    checks++; if (RAMData !== 4'd0) begin errors++; $display("FAIL reset_data got %0d want 0", RAMData); end
    checks++; if (FinGen !== 1'b0) begin errors++; $display("FAIL reset_fin got %b want 0", FinGen); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_run(input logic [1:0] d, input bit toggle, input int lo, input int hi);
    capture(d, toggle);
    checks++; if (nW !== 32) begin errors++; $display("FAIL run%0d_count got %0d want 32", d, nW); end
    for (int i = 0; i < nW && i < 32; i++) begin
      checks++; if (wrAddr[i] !== 5'(i)) begin errors++; $display("FAIL run%0d_addr[%0d] got %0d want %0d", d, i, wrAddr[i], i); end
      checks++; if (wrData[i] !== wrExp[i]) begin errors++; $display("FAIL run%0d_data[%0d] got %0d want %0d", d, i, wrData[i], wrExp[i]); end
      checks++; if (int'(wrData[i]) < lo || int'(wrData[i]) > hi) begin errors++; $display("FAIL run%0d_range[%0d] got %0d want %0d..%0d", d, i, wrData[i], lo, hi); end
`ifdef SEQ_NO_REPEAT_EN
      if (i > 0) begin
        checks++; if (wrData[i] === wrData[i-1]) begin errors++; $display("FAIL run%0d_repeat[%0d] got %0d want not %0d", d, i, wrData[i], wrData[i-1]); end
      end
`endif
    end
`ifdef SEQ_NO_REPEAT_EN
    checks++; if (finAt < 96) begin errors++; $display("FAIL run%0d_latency got %0d want >=96", d, finAt); end
`else
    checks++; if (finAt !== 96) begin errors++; $display("FAIL run%0d_latency got %0d want 96", d, finAt); end
`endif
    checks++; if (busyAfter !== 1'b0) begin errors++; $display("FAIL run%0d_busy_after got %b want 0", d, busyAfter); end
  endtask

  task automatic test_reset_midrun();
    int found;
    found = 0;
    @(negedge Clk); Diff = 2'b01; GoGen = 1'b1;
    @(posedge Clk);
    @(negedge Clk); GoGen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (RAMWrEn && RAMAddr == 5'd9) begin found = 1; break; end
      @(negedge Clk);
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL midrun_10th_write got %0d want 1", found); end
    Rst = 1'b0;
    #1;
    checks++; if (RAMWrEn !== 1'b0) begin errors++; $display("FAIL midrun_wren got %b want 0", RAMWrEn); end
    checks++; if (RAMAddr !== 5'd0) begin errors++; $display("FAIL midrun_addr got %0d want 0", RAMAddr); end
    checks++; if (RAMData !== 4'd0) begin errors++; $display("FAIL midrun_data got %0d want 0", RAMData); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got %b want 0", Busy); end
    found = 0;
    repeat (4) begin @(negedge Clk); if (FinGen) found = 1; end
    checks++; if (found !== 0) begin errors++; $display("FAIL midrun_fin got %0d want 0", found); end
    Rst = 1'b1;
    capture(2'b01, 1'b0);
    checks++; if (nW !== 32) begin errors++; $display("FAIL rerun_count got %0d want 32", nW); end
    checks++; if (wrAddr[0] !== 5'd0) begin errors++; $display("FAIL rerun_first_addr got %0d want 0", wrAddr[0]); end
    checks++; if (wrData[0] !== wrExp[0]) begin errors++; $display("FAIL rerun_first_data got %0d want %0d", wrData[0], wrExp[0]); end
  endtask

  task automatic test_back_to_back();
    int fin [2];
    int nFin, lowCnt;
    nFin = 0; lowCnt = 0;
    @(negedge Clk); Diff = 2'b01; GoGen = 1'b1;
    @(posedge Clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      if (nFin == 1 && !Busy) lowCnt++;
      if (FinGen) begin fin[nFin] = n; nFin++; end
      if (nFin == 2) break;
    end
    GoGen = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (nFin !== 2) begin errors++; $display("FAIL b2b_fin_count got %0d want 2", nFin); end
    if (nFin == 2) begin
      // period of 98 edges leaves 97 cycles between the two pulses
`ifdef SEQ_NO_REPEAT_EN
      checks++; if (fin[1] - fin[0] < 98) begin errors++; $display("FAIL b2b_period got %0d want >=98", fin[1] - fin[0]); end
`else
      checks++; if (fin[1] - fin[0] !== 98) begin errors++; $display("FAIL b2b_period got %0d want 98", fin[1] - fin[0]); end
`endif
    end
    checks++; if (lowCnt !== 1) begin errors++; $display("FAIL b2b_busy_low got %0d want 1", lowCnt); end
  endtask

  task automatic test_repeatable();
    logic [3:0] seqA [32];
    int same;
    do_reset(); repeat (5) @(negedge Clk);
    capture(2'b11, 1'b0);
    for (int i = 0; i < 32; i++) seqA[i] = wrData[i];
    do_reset(); repeat (5) @(negedge Clk);
    capture(2'b11, 1'b0);
    same = 1;
    for (int i = 0; i < 32; i++) if (wrData[i] !== seqA[i]) same = 0;
    checks++; if (same !== 1) begin errors++; $display("FAIL repeat_same_offset got %0d want 1", same); end
    do_reset(); repeat (6) @(negedge Clk);
    capture(2'b11, 1'b0);
    same = 1;
    for (int i = 0; i < 32; i++) if (wrData[i] !== seqA[i]) same = 0;
    checks++; if (same !== 0) begin errors++; $display("FAIL repeat_shifted_offset got %0d want 0", same); end
  endtask

  initial begin
    Rst = 1'b0; GoGen = 1'b0; Diff = 2'b00;
    test_reset();
    test_run(2'b01, 1'b0, 1, 4);
    test_run(2'b11, 1'b1, 0, 9);
    test_run(2'b10, 1'b1, 1, 8);
    test_run(2'b00, 1'b0, 1, 4);
    test_reset_midrun();
    test_back_to_back();
    test_repeatable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
